// File: rtl/kb_pkg.sv
// Shared constants for the keyboard MMIO controller: register map, CTRL bit layout, bus FSM states.
package kb_pkg;

    localparam logic [1:0] KB_ADDR_STATUS = 2'd0;
    localparam logic [1:0] KB_ADDR_DATA   = 2'd1;
    localparam logic [1:0] KB_ADDR_CTRL   = 2'd2;
    localparam logic [1:0] KB_ADDR_DROPS  = 2'd3;

    localparam int unsigned KB_CTRL_CLR_BIT     = 0;
    localparam int unsigned KB_CTRL_IRQ_EN_BIT  = 1;
    localparam int unsigned KB_CTRL_OVR_CLR_BIT = 2;

    typedef enum logic [1:0] {
        KB_IDLE = 2'd0,
        KB_ACK  = 2'd1,
        KB_HOLD = 2'd2
    } kb_state_t;

endpackage

// File: rtl/kb_rx_filter.sv
// Registered UART byte qualification into the keyboard FIFO, with sticky overrun
// detection and a saturating count of dropped (non-ASCII or framing-error) bytes.
module kb_rx_filter #(
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_err,
    input  logic                  kb_full,
    input  logic                  kb_clear,
    input  logic                  ovr_clr,
    input  logic                  drop_clr,
    output logic                  kb_write,
    output logic [6:0]            kb_write_data,
    output logic                  overrun,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic bad;
    logic wr_q;

    assign bad = rx_err | rx_data[7];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q          <= 1'b0;
            kb_write_data <= '0;
            overrun       <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            wr_q <= rx_valid & ~bad & ~kb_full;
            if (rx_valid) begin
                kb_write_data <= rx_data[6:0];
            end
            // drop outranks overrun; a fresh overrun outranks a clear request
            if (rx_valid & ~bad & kb_full) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
            if (drop_clr) begin
                drop_cnt <= '0;
            end else if (rx_valid & bad & (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    // a byte landing in the FIFO-clear cycle is discarded silently
    assign kb_write = wr_q & ~kb_clear;

endmodule

// File: rtl/kb_mmio_ctrl.sv
// CPU-facing register file and single-ack bus FSM for the keyboard FIFO; the
// HOLD state guarantees one pop per DATA read even if the request is held.
module kb_mmio_ctrl
    import kb_pkg::*;
#(
    parameter int unsigned DROP_CNT_W = 8,
    parameter logic        IRQ_EN_RST = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    output logic       irq,
    output logic       kb_write,
    output logic [6:0] kb_write_data,
    output logic       kb_read_en,
    output logic       kb_clear,
    input  logic       kb_status,
    input  logic [6:0] kb_read_data,
    input  logic       kb_full
);

    kb_state_t             state_q, state_d;
    logic [7:0]            rdata_q, rdata_mux;
    logic [2:0]            wctl_q;
    logic [1:0]            addr_q;
    logic                  we_q, pop_q, irq_en;
    logic                  ctrl_wr, drops_wr;
    logic                  overrun;
    logic [DROP_CNT_W-1:0] drop_cnt;
    logic                  unused_wdata;

    assign unused_wdata = ^cpu_wdata[7:3];

    kb_rx_filter #(
        .DROP_CNT_W(DROP_CNT_W)
    ) u_rx_filter (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_err       (rx_err),
        .kb_full      (kb_full),
        .kb_clear     (kb_clear),
        .ovr_clr      (ctrl_wr & wctl_q[KB_CTRL_OVR_CLR_BIT]),
        .drop_clr     (drops_wr),
        .kb_write     (kb_write),
        .kb_write_data(kb_write_data),
        .overrun      (overrun),
        .drop_cnt     (drop_cnt)
    );

    always_comb begin
        rdata_mux = '0;
        if (!cpu_we) begin
            case (cpu_addr)
                KB_ADDR_STATUS: rdata_mux = {4'b0, overrun, irq_en, kb_full, kb_status};
                KB_ADDR_DATA:   rdata_mux = kb_status ? {1'b0, kb_read_data} : 8'h00;
                KB_ADDR_CTRL:   rdata_mux = {6'b0, irq_en, 1'b0};
                default:        rdata_mux = 8'(drop_cnt);
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cpu_ack    = 1'b0;
        cpu_rdata  = '0;
        kb_read_en = 1'b0;
        kb_clear   = 1'b0;
        ctrl_wr    = 1'b0;
        drops_wr   = 1'b0;
        case (state_q)
            KB_IDLE: begin
                if (cpu_req) begin
                    state_d = KB_ACK;
                end
            end
            KB_ACK: begin
                cpu_ack    = 1'b1;
                cpu_rdata  = rdata_q;
                kb_read_en = pop_q;
                ctrl_wr    = we_q & (addr_q == KB_ADDR_CTRL);
                drops_wr   = we_q & (addr_q == KB_ADDR_DROPS);
                kb_clear   = ctrl_wr & wctl_q[KB_CTRL_CLR_BIT];
                state_d    = KB_HOLD;
            end
            KB_HOLD: begin
                if (!cpu_req) begin
                    state_d = KB_IDLE;
                end
            end
            default: state_d = KB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= KB_IDLE;
            rdata_q <= '0;
            wctl_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            pop_q   <= 1'b0;
            irq_en  <= IRQ_EN_RST;
        end else begin
            state_q <= state_d;
            if ((state_q == KB_IDLE) && cpu_req) begin
                rdata_q <= rdata_mux;
                wctl_q  <= cpu_wdata[2:0];
                addr_q  <= cpu_addr;
                we_q    <= cpu_we;
                pop_q   <= ~cpu_we & (cpu_addr == KB_ADDR_DATA) & kb_status;
            end
            if (ctrl_wr) begin
                irq_en <= wctl_q[KB_CTRL_IRQ_EN_BIT];
            end
        end
    end

    assign irq = irq_en & (kb_status | overrun);

endmodule

// File: tb/tb_kb_mmio_ctrl.sv
// Self-checking bench: a queue-based keyboard FIFO environment plus a byte-stream
// reference model of the controller's register and RX rules.
module tb_kb_mmio_ctrl;

    localparam int CAP = 4;

    logic       clk, reset_n;
    logic       rx_valid, rx_err;
    logic [7:0] rx_data;
    logic       cpu_req, cpu_we;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       cpu_ack, irq;
    logic       kb_write, kb_read_en, kb_clear;
    logic [6:0] kb_write_data, kb_read_data;
    logic       kb_status, kb_full;

    kb_mmio_ctrl #(
        .DROP_CNT_W(8),
        .IRQ_EN_RST(1'b0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_err       (rx_err),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ack      (cpu_ack),
        .irq          (irq),
        .kb_write     (kb_write),
        .kb_write_data(kb_write_data),
        .kb_read_en   (kb_read_en),
        .kb_clear     (kb_clear),
        .kb_status    (kb_status),
        .kb_read_data (kb_read_data),
        .kb_full      (kb_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO environment
    logic [6:0] fq[$];
    int         fifo_n;
    logic [6:0] fifo_head;
    logic       force_full;
    int         wr_cnt, pop_cnt, clr_cnt, ack_cnt;

    initial begin
        fifo_n = 0; fifo_head = '0;
        wr_cnt = 0; pop_cnt = 0; clr_cnt = 0; ack_cnt = 0;
    end

    always @(posedge clk) begin
        if (kb_write)   wr_cnt++;
        if (kb_read_en) pop_cnt++;
        if (kb_clear)   clr_cnt++;
        if (cpu_ack)    ack_cnt++;
        if (!reset_n || kb_clear) begin
            fq.delete();
        end else begin
            if (kb_read_en && fq.size() > 0) void'(fq.pop_front());
            if (kb_write) fq.push_back(kb_write_data);
        end
        fifo_n    <= fq.size();
        fifo_head <= (fq.size() > 0) ? fq[0] : 7'h00;
    end

    assign kb_status    = (fifo_n != 0);
    assign kb_read_data = fifo_head;
    assign kb_full      = (fifo_n >= CAP) || force_full;

    // reference model
    logic [6:0] m_q[$];
    logic       m_overrun, m_irq_en;
    int         m_drops;
    int         n_tests, n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic m_full();
        return (m_q.size() >= CAP) || force_full;
    endfunction

    function automatic logic m_irq();
        return m_irq_en && ((m_q.size() > 0) || m_overrun);
    endfunction

    task automatic send_rx(input logic [7:0] d, input logic e);
        int   w0;
        logic bad, full, exp_wr;
        w0     = wr_cnt;
        bad    = e | d[7];
        full   = m_full();
        exp_wr = !bad && !full;
        rx_valid = 1'b1; rx_data = d; rx_err = e;
        tick();
        rx_valid = 1'b0; rx_err = 1'b0;
        check("rx_kb_write", kb_write, exp_wr);
        if (exp_wr) check("rx_kb_write_data", kb_write_data, d[6:0]);
        if (bad)       m_drops = (m_drops < 255) ? m_drops + 1 : 255;
        else if (full) m_overrun = 1'b1;
        else           m_q.push_back(d[6:0]);
        tick();
        check("rx_write_count", wr_cnt - w0, exp_wr);
    endtask

    task automatic cpu_access(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                              input int hold, output logic [7:0] rd);
        int         a0, p0, c0;
        logic       ne, exp_pop, exp_clr;
        logic [7:0] exp_rd;
        a0 = ack_cnt; p0 = pop_cnt; c0 = clr_cnt;
        ne = (m_q.size() > 0);
        exp_pop = !we && addr == 2'd1 && ne;
        exp_clr = we && addr == 2'd2 && wd[0];
        case (addr)
            2'd0:    exp_rd = {4'b0, m_overrun, m_irq_en, m_full(), ne};
            2'd1:    exp_rd = ne ? {1'b0, m_q[0]} : 8'h00;
            2'd2:    exp_rd = {6'b0, m_irq_en, 1'b0};
            default: exp_rd = 8'(m_drops);
        endcase
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        tick();
        check("ack_latency", cpu_ack, 1'b1);
        if (!we) check($sformatf("rdata_addr%0d", addr), cpu_rdata, exp_rd);
        check("read_en", kb_read_en, exp_pop);
        check("clear", kb_clear, exp_clr);
        rd = cpu_rdata;
        repeat (hold) tick();
        cpu_req = 1'b0;
        tick();
        tick();
        check("ack_once", ack_cnt - a0, 1);
        check("pop_once", pop_cnt - p0, exp_pop);
        check("clear_count", clr_cnt - c0, exp_clr);
        check("rdata_idle", cpu_rdata, 8'h00);
        if (exp_pop) void'(m_q.pop_front());
        if (we && addr == 2'd2) begin
            if (wd[0]) m_q.delete();
            m_irq_en = wd[1];
            if (wd[2]) m_overrun = 1'b0;
        end
        if (we && addr == 2'd3) m_drops = 0;
        check("irq", irq, m_irq());
    endtask

    initial begin
        logic [7:0] rd;
        int         w0, c0;
        n_tests = 0; n_fail = 0;
        m_overrun = 1'b0; m_irq_en = 1'b0; m_drops = 0;
        force_full = 1'b0;
        reset_n = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; rx_data = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) tick();
        check("rst_ack", cpu_ack, 1'b0);
        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_write", kb_write, 1'b0);
        check("rst_read_en", kb_read_en, 1'b0);
        check("rst_clear", kb_clear, 1'b0);
        check("rst_irq", irq, 1'b0);
        reset_n = 1'b1;
        tick();

        send_rx(8'h41, 1'b0);
        cpu_access(1'b0, 2'd0, 8'h00, 0, rd);
        cpu_access(1'b0, 2'd1, 8'h00, 5, rd);
        cpu_access(1'b0, 2'd1, 8'h00, 2, rd);

        send_rx(8'hC1, 1'b0);
        send_rx(8'h41, 1'b1);
        for (int i = 0; i < 256; i++) begin
            send_rx({1'b1, 7'($urandom)}, 1'($urandom));
        end
        cpu_access(1'b0, 2'd3, 8'h00, 0, rd);
        check("drops_saturated", rd, 8'hFF);
        cpu_access(1'b1, 2'd3, 8'h5A, 0, rd);
        cpu_access(1'b0, 2'd3, 8'h00, 1, rd);

        force_full = 1'b1;
        tick();
        send_rx(8'h42, 1'b0);
        cpu_access(1'b0, 2'd0, 8'h00, 0, rd);
        cpu_access(1'b1, 2'd2, 8'h02, 0, rd);
        cpu_access(1'b1, 2'd2, 8'h06, 0, rd);
        force_full = 1'b0;
        tick();

        // RX byte landing in the FIFO-clear cycle
        send_rx(8'h30, 1'b0);
        send_rx(8'h80, 1'b0);
        force_full = 1'b1;
        tick();
        send_rx(8'h31, 1'b0);
        force_full = 1'b0;
        tick();
        w0 = wr_cnt; c0 = clr_cnt;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 2'd2; cpu_wdata = 8'h03;
        rx_valid = 1'b1; rx_data = 8'h55; rx_err = 1'b0;
        tick();
        rx_valid = 1'b0;
        check("coinc_clear", kb_clear, 1'b1);
        check("coinc_write", kb_write, 1'b0);
        cpu_req = 1'b0;
        tick();
        tick();
        check("coinc_write_count", wr_cnt - w0, 0);
        check("coinc_clear_count", clr_cnt - c0, 1);
        m_q.delete();
        m_irq_en = 1'b1;
        cpu_access(1'b0, 2'd0, 8'h00, 0, rd);
        check("coinc_status", rd, 8'h0C);
        cpu_access(1'b0, 2'd3, 8'h00, 0, rd);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(1) == 0) begin
                send_rx({($urandom_range(3) == 0), 7'($urandom)}, ($urandom_range(7) == 0));
            end else begin
                cpu_access(1'($urandom), 2'($urandom), 8'($urandom), $urandom_range(3), rd);
            end
        end

        // reset while a transaction sits in the ACK cycle
        force_full = 1'b1;
        tick();
        send_rx(8'h44, 1'b0);
        force_full = 1'b0;
        send_rx(8'hFF, 1'b0);
        send_rx(8'h45, 1'b0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 2'd0;
        tick();
        check("pre_rst_ack", cpu_ack, 1'b1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_ack", cpu_ack, 1'b0);
        check("mid_rst_read_en", kb_read_en, 1'b0);
        check("mid_rst_rdata", cpu_rdata, 8'h00);
        reset_n = 1'b1;
        cpu_req = 1'b0;
        tick();
        m_q.delete(); m_irq_en = 1'b0; m_overrun = 1'b0; m_drops = 0;
        cpu_access(1'b0, 2'd0, 8'h00, 0, rd);
        check("post_rst_status", rd, 8'h00);
        cpu_access(1'b0, 2'd3, 8'h00, 0, rd);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
